fir_tap_sequencer: RTL and testbench
====================================

// Module: fir_tap_sequencer
// PURPOSE
//   Time-multiplexed (serial) FIR controller and accumulator around the coefficient ROM.
//   Accepts one input sample per valid/ready handshake and stores it in a circular sample buffer.
//   Steps the ROM address through all N_TAPS coefficients, one per cycle.
//   Multiply-accumulates each coefficient with the matching delayed sample, then presents y[n].
//   Sits between the sample source and the ROM. Owns rom_address; the ROM's 1-cycle read latency is absorbed here.
// PARAMETERS
//   WIDTH_DATA   8    input sample width, signed two's complement
//   WIDTH_COEF0  8    coefficient width (ROM data), signed two's complement
//   N_TAPS       16   number of taps; must equal 2**LOG2_N_TAPS
//   LOG2_N_TAPS  4    address / pointer width
//   WIDTH_ACC    WIDTH_DATA+WIDTH_COEF0+LOG2_N_TAPS (20)   accumulator and output width
// PORTS
//   clk          in   1            clock
//   reset        in   1            reset, synchronous, active-high
//   in_valid     in   1            input sample valid
//   in_data      in   WIDTH_DATA   input sample x[n]
//   in_ready     out  1            controller can accept a sample
//   rom_address  out  LOG2_N_TAPS  coefficient ROM address
//   rom_data     in   WIDTH_COEF0  ROM data; registered, valid 1 cycle after rom_address
//   out_valid    out  1            y[n] valid; held until accepted
//   out_data     out  WIDTH_ACC    y[n] = sum_k coef[k]*x[n-k], k=0..N_TAPS-1
//   out_ready    in   1            consumer accepts out_data
// BEHAVIOUR
//   Reset values:
//     - state=IDLE; wr_ptr=0; tap counter=0; acc=0; all N_TAPS buffer entries=0.
//     - in_ready=0 while reset is high.
//     - rom_address=0, out_valid=0, out_data=0.
//   Reset mid-operation: aborts immediately, no out_valid is produced, and the history is cleared.
//   FSM states: IDLE -> MAC -> DRAIN -> DONE -> IDLE.
//   IDLE:
//     - in_ready=1.
//     - On in_valid&in_ready: buf[wr_ptr]<=in_data, base<=wr_ptr, wr_ptr<=wr_ptr+1 (mod N_TAPS), acc<=0, k<=0, go to MAC.
//   MAC (N_TAPS cycles):
//     - rom_address=k.
//     - samp_q<=buf[(base-k) mod N_TAPS]; pipe_v<=1.
//     - When pipe_v is set: acc<=acc+sext(samp_q)*sext(rom_data), full-precision signed.
//     - k increments each cycle; after k=N_TAPS-1, go to DRAIN.
//   DRAIN (1 cycle):
//     - The last product is accumulated; pipe_v<=0; go to DONE.
//   DONE:
//     - out_valid=1; out_data=acc, held stable.
//     - On out_ready, go to IDLE next cycle.
//   rom_address=0 in every state other than MAC.
//   Timing and handshake:
//     - Latency: out_valid first high N_TAPS+2 cycles after the accepting edge.
//     - Minimum sample period is N_TAPS+3 cycles.
//   Backpressure: in_ready=0 in MAC/DRAIN/DONE. in_valid in those states is ignored; the source holds the sample.
//   Arithmetic:
//     - No saturation or rounding; WIDTH_ACC is sized so the worst case cannot overflow.
//     - out_data is the raw accumulator.
//   Buffer wrap: the pointer wraps modulo N_TAPS, so the oldest sample is overwritten. Before N_TAPS samples have arrived, missing history reads as 0.
//   out_valid&out_ready in the same cycle as in_valid: the sample is not accepted until IDLE (next cycle).
// STRUCTURE
//   fir_pkg:
//     - State localparams IDLE/MAC/DRAIN/DONE (2-bit encoding).
//     - WIDTH_ACC derivation.
//     - Shared with the ROM and top level.
//   Sub-module fir_sample_buffer:
//     - N_TAPS x WIDTH_DATA register file with synchronous write and registered indexed read.
//     - Cleared by reset.
//   The controller holds the FSM, tap counter, pointers, pipe_v and the accumulator.
//   The ROM is instantiated externally on the same clk/reset.
// TESTING
//   Bench loads rom.mem with coef[k] = k+1 for k=0..15 unless stated otherwise.
//   1 Impulse: x = 1,0,0,...(17 samples) -> out_data = 1,2,...,16, then 0.
//   2 Timing: sample accepted at edge t -> rom_address 0..15 on cycles t+1..t+16; out_valid rises at t+18.
//   3 Extremes: all coef = -128, x = -128 x16 -> 16th output = 262144 with no overflow; then x = 127 x16 -> -260096.
//   4 Backpressure: out_ready low 5 cycles in DONE -> out_valid and out_data stable, in_ready=0, in_valid ignored.
//   5 Reset at MAC tap 7 -> no out_valid; next impulse reproduces scenario 1 exactly (history cleared).
//   6 Step with wrap: 20 samples of 1 -> outputs 1,3,6,...,136, then 136 x4 (wr_ptr wraps cleanly).

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants and state encoding for the serial FIR datapath.
// Used by the tap sequencer, its sample buffer and the coefficient ROM.
package fir_pkg;

  localparam int DEF_WIDTH_DATA  = 8;
  localparam int DEF_WIDTH_COEF0 = 8;
  localparam int DEF_LOG2_N_TAPS = 4;
  localparam int DEF_N_TAPS      = 2 ** DEF_LOG2_N_TAPS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fir_state_e;

  // Growth of log2(taps) bits covers the worst-case sum of products.
  function automatic int fir_acc_width(
    input int wd,
    input int wc,
    input int lg
  );
    return wd + wc + lg;
  endfunction

  localparam int DEF_WIDTH_ACC =
    fir_acc_width(DEF_WIDTH_DATA, DEF_WIDTH_COEF0, DEF_LOG2_N_TAPS);

endpackage

// File: rtl/fir_sample_buffer.sv
// Circular sample history: synchronous write, registered indexed read.
// Reset clears every entry so missing history reads as zero.
module fir_sample_buffer
  import fir_pkg::*;
#(
  parameter int WIDTH_DATA  = DEF_WIDTH_DATA,
  parameter int N_TAPS      = DEF_N_TAPS,
  parameter int LOG2_N_TAPS = DEF_LOG2_N_TAPS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en_i,
  input  logic [LOG2_N_TAPS-1:0] wr_addr_i,
  input  logic [WIDTH_DATA-1:0]  wr_data_i,
  input  logic [LOG2_N_TAPS-1:0] rd_addr_i,
  output logic [WIDTH_DATA-1:0]  rd_data_o
);

  logic [WIDTH_DATA-1:0] mem_q [N_TAPS];
  logic [WIDTH_DATA-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_TAPS; i++) begin
        mem_q[i] <= '0;
      end
      rd_q <= '0;
    end else begin
      if (wr_en_i) begin
        mem_q[wr_addr_i] <= wr_data_i;
      end
      rd_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_q;

endmodule

// File: rtl/fir_tap_sequencer.sv
// Serial FIR controller: walks the coefficient ROM one tap per cycle
// and multiply-accumulates against the matching delayed sample.
module fir_tap_sequencer
  import fir_pkg::*;
#(
  parameter int WIDTH_DATA  = DEF_WIDTH_DATA,
  parameter int WIDTH_COEF0 = DEF_WIDTH_COEF0,
  parameter int N_TAPS      = DEF_N_TAPS,
  parameter int LOG2_N_TAPS = DEF_LOG2_N_TAPS,
  parameter int WIDTH_ACC   =
    fir_acc_width(WIDTH_DATA, WIDTH_COEF0, LOG2_N_TAPS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [WIDTH_DATA-1:0]  in_data,
  output logic                   in_ready,
  output logic [LOG2_N_TAPS-1:0] rom_address,
  input  logic [WIDTH_COEF0-1:0] rom_data,
  output logic                   out_valid,
  output logic [WIDTH_ACC-1:0]   out_data,
  input  logic                   out_ready
);

  localparam int WP = WIDTH_DATA + WIDTH_COEF0;
  localparam logic [LOG2_N_TAPS-1:0] K_LAST =
    LOG2_N_TAPS'(N_TAPS - 1);

  fir_state_e state_q, state_d;
  logic [LOG2_N_TAPS-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG2_N_TAPS-1:0] base_q, base_d;
  logic [LOG2_N_TAPS-1:0] k_q, k_d;
  logic                   pipe_v_q, pipe_v_d;
  logic signed [WIDTH_ACC-1:0] acc_q, acc_d;

  logic                   buf_we;
  logic [LOG2_N_TAPS-1:0] rd_addr;
  logic [WIDTH_DATA-1:0]  samp_q;
  logic signed [WP-1:0]   prod;
  logic signed [WIDTH_ACC-1:0] prod_ext;

  fir_sample_buffer #(
    .WIDTH_DATA  (WIDTH_DATA),
    .N_TAPS      (N_TAPS),
    .LOG2_N_TAPS (LOG2_N_TAPS)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (buf_we),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (in_data),
    .rd_addr_i (rd_addr),
    .rd_data_o (samp_q)
  );

  // samp_q and rom_data both lag k by one cycle, so they pair up.
  assign rd_addr  = base_q - k_q;
  assign prod     = $signed(samp_q) * $signed(rom_data);
  assign prod_ext = {{(WIDTH_ACC-WP){prod[WP-1]}}, prod};

  assign in_ready    = (state_q == IDLE) & ~reset;
  assign rom_address = (state_q == MAC) ? k_q : '0;
  assign out_valid   = (state_q == DONE);
  assign out_data    = acc_q;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    base_d   = base_q;
    k_d      = k_q;
    pipe_v_d = pipe_v_q;
    acc_d    = acc_q;
    buf_we   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          buf_we   = 1'b1;
          base_d   = wr_ptr_q;
          wr_ptr_d = wr_ptr_q + 1'b1;
          acc_d    = '0;
          k_d      = '0;
          pipe_v_d = 1'b0;
          state_d  = MAC;
        end
      end
      MAC: begin
        pipe_v_d = 1'b1;
        k_d      = k_q + 1'b1;
        if (pipe_v_q) begin
          acc_d = acc_q + prod_ext;
        end
        if (k_q == K_LAST) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        acc_d    = acc_q + prod_ext;
        pipe_v_d = 1'b0;
        state_d  = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      base_q   <= '0;
      k_q      <= '0;
      pipe_v_q <= 1'b0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      base_q   <= base_d;
      k_q      <= k_d;
      pipe_v_q <= pipe_v_d;
      acc_q    <= acc_d;
    end
  end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Bench for fir_tap_sequencer with a registered coefficient ROM model.
module tb_fir_tap_sequencer;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [3:0]  rom_address;
  logic [7:0]  rom_data;
  logic        out_valid;
  logic [19:0] out_data;
  logic        out_ready;

  logic [7:0] coef [16];
  int exp_q [$];
  int tests;
  int fails;

  fir_tap_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .rom_address (rom_address),
    .rom_data    (rom_data),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (reset) rom_data <= '0;
    else       rom_data <= coef[rom_address];
  end

  task automatic load_ramp();
    for (int k = 0; k < 16; k++) coef[k] = 8'(k + 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
  endtask

  // Waits for in_ready, presents x for one accepting edge.
  task automatic drive_sample(input int x, input int exp, output bit to);
    int n;
    n = 0;
    to = 1'b0;
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      to = 1'b1;
    end else begin
      exp_q.push_back(exp);
      in_valid = 1'b1;
      in_data  = 8'(x);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_out(output bit to);
    int n;
    n = 0;
    while (!out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    to = !out_valid;
  endtask

  task automatic test_reset();
    int got;
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b1;
    in_data = 8'd9;
    @(posedge clk);
    @(negedge clk);
    tests++;
    got = int'(out_data);
    if (in_ready !== 1'b0 || rom_address !== 4'd0 ||
        out_valid !== 1'b0 || got !== 0) begin
      fails++;
      $display("FAIL reset_vals rdy=%b addr=%0d ov=%b od=%0d, need 0 0 0 0",
               in_ready, rom_address, out_valid, got);
    end
    in_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_idle_ready in_ready=%b need 1", in_ready);
    end
  endtask

  task automatic test_impulse(input string tag);
    bit to;
    int got, exp;
    for (int i = 0; i < 17; i++) begin
      drive_sample((i == 0) ? 1 : 0, (i < 16) ? i + 1 : 0, to);
      if (!to) wait_out(to);
      tests++;
      got = $signed(out_data);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      if (to || got !== exp) begin
        fails++;
        $display("FAIL %s[%0d] out_data=%0d timeout=%0b need %0d",
                 tag, i, got, to, exp);
      end
    end
  endtask

  task automatic test_timing();
    bit to;
    int got, exp;
    logic [3:0] ea;
    logic ev;
    do_reset();
    exp_q.push_back(5);
    in_valid = 1'b1;
    in_data = 8'd5;
    @(posedge clk);
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (c == 1) in_valid = 1'b0;
      ea = (c <= 16) ? 4'(c - 1) : 4'd0;
      ev = (c == 18);
      tests++;
      if (rom_address !== ea || out_valid !== ev) begin
        fails++;
        $display("FAIL timing_c%0d addr=%0d ov=%b need %0d %b",
                 c, rom_address, out_valid, ea, ev);
      end
    end
    tests++;
    got = $signed(out_data);
    exp = exp_q.pop_front();
    if (got !== exp || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL timing_data out_data=%0d rdy=%b need %0d 0",
               got, in_ready, exp);
    end
    to = 1'b0;
  endtask

  task automatic test_backpressure();
    bit to;
    int got, exp;
    do_reset();
    out_ready = 1'b0;
    drive_sample(3, 3, to);
    if (!to) wait_out(to);
    exp = exp_q.pop_front();
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data = 8'd99;
      tests++;
      got = $signed(out_data);
      if (to || out_valid !== 1'b1 || got !== exp || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold%0d ov=%b od=%0d rdy=%b need 1 %0d 0",
                 c, out_valid, got, in_ready, exp);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_release rdy=%b ov=%b need 1 0", in_ready, out_valid);
    end
    exp_q.push_back(99 * 1 + 3 * 2);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(to);
    tests++;
    got = $signed(out_data);
    exp = exp_q.pop_front();
    if (to || got !== exp) begin
      fails++;
      $display("FAIL bp_held_sample out_data=%0d timeout=%0b need %0d",
               got, to, exp);
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    int n;
    bit seen;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive_sample(7, 7 * ((i + 1) * (i + 2) / 2), to);
      if (!to) wait_out(to);
      void'(exp_q.pop_front());
    end
    drive_sample(7, 0, to);
    n = 0;
    while (rom_address !== 4'd7 && n < 30) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (rom_address !== 4'd7) begin
      fails++;
      $display("FAIL mid_tap7 addr=%0d need 7", rom_address);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    seen = 1'b0;
    for (int c = 0; c < 25; c++) begin
      if (out_valid) seen = 1'b1;
      @(negedge clk);
    end
    tests++;
    if (seen) begin
      fails++;
      $display("FAIL mid_abort out_valid=1 need 0");
    end
    test_impulse("mid_impulse");
  endtask

  task automatic test_extremes();
    bit to;
    int got, exp;
    for (int k = 0; k < 16; k++) coef[k] = 8'h80;
    do_reset();
    for (int i = 1; i <= 32; i++) begin
      if (i <= 16) exp = 16384 * i;
      else exp = -16256 * (i - 16) + 16384 * (32 - i);
      drive_sample((i <= 16) ? -128 : 127, exp, to);
      if (!to) wait_out(to);
      tests++;
      got = $signed(out_data);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      if (to || got !== exp) begin
        fails++;
        $display("FAIL extreme[%0d] out_data=%0d timeout=%0b need %0d",
                 i, got, to, exp);
      end
    end
    load_ramp();
  endtask

  task automatic test_step_wrap();
    bit to;
    int got, exp, m;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      m = (i + 1 < 16) ? i + 1 : 16;
      drive_sample(1, m * (m + 1) / 2, to);
      if (!to) wait_out(to);
      tests++;
      got = $signed(out_data);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      if (to || got !== exp) begin
        fails++;
        $display("FAIL step[%0d] out_data=%0d timeout=%0b need %0d",
                 i, got, to, exp);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    load_ramp();
    repeat (2) @(posedge clk);
    test_reset();
    do_reset();
    test_impulse("impulse");
    test_timing();
    test_backpressure();
    test_reset_mid();
    test_extremes();
    test_step_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
